// File: rtl/cdma_ser_scheduler_pkg.sv
// Shared types and helpers for the CDMA serial scheduler and other router arbiters.
package cdma_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int CDMA_N_REQ  = 4;
  localparam int CDMA_DATA_W = 4;

  // Winner is the first set bit scanning ptr+1, ptr+2, ... modulo n_req (n_req <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                         input logic [3:0] n_req);
    logic [3:0] idx_s;
    logic [2:0] win_s;
    win_s = ptr;
    for (int k = 8; k >= 1; k--) begin
      idx_s = 4'(ptr) + 4'(k);
      if (idx_s >= n_req) begin
        idx_s = idx_s - n_req;
      end else begin
        idx_s = idx_s;
      end
      if ((4'(k) <= n_req) && valid[idx_s[2:0]]) begin
        win_s = idx_s[2:0];
      end else begin
        win_s = win_s;
      end
    end
    return win_s;
  endfunction

  function automatic logic even_parity(input logic [15:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cdma_ser_scheduler_if.sv
// Requester-side valid/ready handshake bundle for the CDMA serial scheduler.
interface cdma_ser_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 4
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/cdma_ser_scheduler_rr.sv
// Round-robin arbiter: combinational pick from a registered last-winner pointer.
module cdma_rr_arbiter
  import cdma_pkg::*;
#(
  parameter int N_REQ = CDMA_N_REQ,
  localparam int CH_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  input  logic             grant_upd,
  output logic [CH_W-1:0]  winner,
  output logic             any_valid
);

  logic [CH_W-1:0] rr_ptr_r;

  // Select the next requester after the last winner.
  always_comb begin
    winner    = CH_W'(rr_pick(8'(valid), 3'(rr_ptr_r), 4'(N_REQ)));
    any_valid = |valid;
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= CH_W'(N_REQ - 1);
    end else if (grant_upd) begin
      rr_ptr_r <= winner;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/cdma_ser_scheduler.sv
// Round-robin parallel-to-serial scheduler, MSB first with channel tag.
// Optional trailing even-parity bit when CDMA_SER_PARITY_EN is defined.
module cdma_ser_scheduler
  import cdma_pkg::*;
#(
  parameter int N_REQ  = CDMA_N_REQ,
  parameter int DATA_W = CDMA_DATA_W,
  localparam int CH_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  cdma_ser_scheduler_if.slave   req,
  input  logic                  ser_en,
  output logic                  ser_out,
  output logic                  ser_valid,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic [CH_W-1:0]       ser_chan,
  output logic                  busy
);

`ifdef CDMA_SER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e               state_r;
  logic [FRAME_LEN-1:0] shift_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [CH_W-1:0]      chan_r;
  logic [CH_W-1:0]      winner_s;
  logic                 any_valid_s;
  logic                 grant_s;
  logic [DATA_W-1:0]    word_s;
  logic [FRAME_LEN-1:0] load_s;

  cdma_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req.req_valid),
    .grant_upd (grant_s),
    .winner    (winner_s),
    .any_valid (any_valid_s)
  );

  // Grant decode and frame image; the parity bit rides in the shift register's LSB.
  always_comb begin
    grant_s = (state_r == IDLE) && any_valid_s;
    word_s  = req.req_data[int'(winner_s)*DATA_W +: DATA_W];
`ifdef CDMA_SER_PARITY_EN
    load_s  = {word_s, even_parity(16'(word_s))};
`else
    load_s  = word_s;
`endif
    if (grant_s) begin
      req.req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
    end else begin
      req.req_ready = {N_REQ{1'b0}};
    end
  end

  // Frame FSM with shift/count datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= {FRAME_LEN{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      chan_r    <= {CH_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            shift_r   <= load_s;
            chan_r    <= winner_s;
            bit_cnt_r <= {CNT_W{1'b0}};
            state_r   <= SHIFT;
          end else begin
            state_r   <= IDLE;
          end
        end
        SHIFT: begin
          if (ser_en) begin
            // Zero fill leaves the register clear once the frame is drained.
            shift_r <= {shift_r[FRAME_LEN-2:0], 1'b0};
            if (bit_cnt_r == LAST_CNT) begin
              bit_cnt_r <= {CNT_W{1'b0}};
              state_r   <= IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
              state_r   <= SHIFT;
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Serial outputs decode directly from registered state.
  always_comb begin
    ser_valid = (state_r == SHIFT);
    busy      = (state_r == SHIFT);
    ser_out   = shift_r[FRAME_LEN-1];
    ser_first = (state_r == SHIFT) && (bit_cnt_r == {CNT_W{1'b0}});
    ser_last  = (state_r == SHIFT) && (bit_cnt_r == LAST_CNT);
    ser_chan  = chan_r;
  end

endmodule
